// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the 74151 scan controller.
package mux_scan_pkg;

    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int MAX_RETRY_DEF     = 3;

    // Counter widths sized for the largest legal parameter values (15 and 7).
    localparam int SETTLE_W = 4;
    localparam int RETRY_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE1,
        SAMPLE2,
        DONE
    } state_t;

endpackage

// File: rtl/mux_scan_timer.sv
// Loadable settle down-counter; o_done is high once the count reaches zero.
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic                clk,
    input  logic                _reset,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_done
);

    logic [SETTLE_W-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the eight inputs of a 74151 mux, double-sampling Y per select value
// with bounded retries, and publishes the completed byte atomically.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       start,
    output logic [2:0] S,
    output logic       _E,
    input  logic       Y,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    state_t               r_state;
    logic [2:0]           r_s;
    logic                 r_e_n;
    logic                 r_hold;
    logic [RETRY_W-1:0]   r_retry;
    logic [7:0]           r_shadow;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_err;

    state_t               w_state_next;
    logic [2:0]           w_s_next;
    logic                 w_e_n_next;
    logic                 w_hold_next;
    logic [RETRY_W-1:0]   w_retry_next;
    logic [7:0]           w_shadow_next;
    logic [7:0]           w_data_next;
    logic                 w_valid_next;
    logic                 w_err_next;
    logic                 w_load;
    logic                 w_advance;
    logic                 w_bit;
    logic                 w_timer_done;

    mux_scan_timer u_timer (
        .clk        (clk),
        ._reset     (_reset),
        .i_load     (w_load),
        .i_load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
        .i_dec      (r_state == SETTLE),
        .o_done     (w_timer_done)
    );

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_next  = r_state;
        w_s_next      = r_s;
        w_e_n_next    = r_e_n;
        w_hold_next   = r_hold;
        w_retry_next  = r_retry;
        w_shadow_next = r_shadow;
        w_data_next   = r_data;
        w_valid_next  = 1'b0;
        w_err_next    = r_err;
        w_load        = 1'b0;
        w_advance     = 1'b0;
        w_bit         = Y;

        case (r_state)
            IDLE: begin
                w_e_n_next = 1'b1;
                w_s_next   = 3'd0;
                if (start) begin
                    w_state_next = SETTLE;
                    w_e_n_next   = 1'b0;
                    w_retry_next = '0;
                    w_err_next   = 1'b0;
                    w_load       = 1'b1;
                end
            end
            SETTLE: begin
                if (w_timer_done) begin
                    w_state_next = SAMPLE1;
                end
            end
            SAMPLE1: begin
                w_hold_next  = Y;
                w_state_next = SAMPLE2;
            end
            SAMPLE2: begin
                if (Y == r_hold) begin
                    w_bit     = r_hold;
                    w_advance = 1'b1;
                end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
                    w_retry_next = r_retry + 1'b1;
                    w_state_next = SETTLE;
                    w_load       = 1'b1;
                end else begin
                    // Retries exhausted: keep the latest sample and flag the scan.
                    w_err_next = 1'b1;
                    w_advance  = 1'b1;
                end
                if (w_advance) begin
                    w_shadow_next[r_s] = w_bit;
                    if (r_s == 3'd7) begin
                        w_state_next = DONE;
                        w_data_next  = w_shadow_next;
                        w_valid_next = 1'b1;
                        w_e_n_next   = 1'b1;
                    end else begin
                        w_s_next     = r_s + 3'd1;
                        w_retry_next = '0;
                        w_state_next = SETTLE;
                        w_load       = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_s_next     = 3'd0;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: the shadow byte is cleared by reset too, so data can never expose stale bits.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state  <= IDLE;
            r_s      <= 3'd0;
            r_e_n    <= 1'b1;
            r_hold   <= 1'b0;
            r_retry  <= '0;
            r_shadow <= 8'h00;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_s      <= w_s_next;
            r_e_n    <= w_e_n_next;
            r_hold   <= w_hold_next;
            r_retry  <= w_retry_next;
            r_shadow <= w_shadow_next;
            r_data   <= w_data_next;
            r_valid  <= w_valid_next;
            r_busy   <= (w_state_next != IDLE);
            r_err    <= w_err_next;
        end
    end

    assign S     = r_s;
    assign _E    = r_e_n;
    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule
